// File: rtl/serial_sub_ctrl_pkg.sv
// Shared definitions for the bit-serial subtraction controller.
package serial_sub_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/serial_sub_ctrl_if.sv
// Request/result bundle of the serial subtractor: start handshake, operands, result flags.
interface serial_sub_ctrl_if
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout, ovf
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout, ovf
  );

endinterface

// File: rtl/serial_sub_ctrl_fsub.sv
// 1-bit full-subtractor cell: diff = a - b - c, borr set when the result underflows.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic diff,
  output logic borr
);

  assign diff = a ^ b ^ c;
  assign borr = (~a & (b | c)) | (a & b & c);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial a - b - bin controller: one full-subtractor cell iterated LSB first.
module serial_sub_ctrl
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_sub_ctrl_if.slave  bus
);

  localparam int unsigned     CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_nstate;

  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic             r_borrow;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_res;
  logic             r_a_msb;
  logic             r_b_msb;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_ovf;
  logic             r_busy;
  logic             r_done;

  logic             w_d;
  logic             w_bo;
  logic             w_last;
  logic             w_ovf;
  logic [WIDTH-1:0] w_res_next;

  full_subtractor u_cell (
    .a    (r_a_sh[0]),
    .b    (r_b_sh[0]),
    .c    (r_borrow),
    .diff (w_d),
    .borr (w_bo)
  );

  // New bit enters at the MSB; written as a shifted concat so WIDTH=1 needs no special case
  assign w_res_next = WIDTH'({w_d, r_res} >> 1);
  assign w_last     = (r_cnt == LAST);
  assign w_ovf      = (r_a_msb ^ r_b_msb) & (w_res_next[WIDTH-1] ^ r_a_msb);

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.diff = r_diff;
  assign bus.bout = r_bout;
  assign bus.ovf  = r_ovf;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nstate;
  end

  // Next-state: accept only in IDLE, leave RUN after the last bit, DONE lasts one cycle
  always_comb begin
    w_nstate = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_nstate = RUN;
      RUN:     if (w_last)    w_nstate = DONE;
      DONE:    w_nstate = IDLE;
      default: w_nstate = IDLE;
    endcase
  end

  // Operand capture, serial iteration and result load; status flags follow the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
      r_res    <= '0;
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_busy <= (w_nstate != IDLE);
      r_done <= (w_nstate == DONE);
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_a_sh   <= bus.a;
            r_b_sh   <= bus.b;
            r_borrow <= bus.bin;
            r_cnt    <= '0;
            r_a_msb  <= bus.a[WIDTH-1];
            r_b_msb  <= bus.b[WIDTH-1];
          end
        end
        RUN: begin
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_res    <= w_res_next;
          r_borrow <= w_bo;
          r_cnt    <= r_cnt + CW'(1);
          if (w_last) begin
            r_diff <= w_res_next;
            r_bout <= w_bo;
            r_ovf  <= w_ovf;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
